fadd_arbiter: RTL
=================

Name: fadd_arbiter

Overview:
- Round-robin scheduler that shares one streaming floating-point adder among NUM_REQ requester streams.
- Grants one requester per packet and holds the grant until that requester's tlast beat is accepted.
- Tags each issued beat with the requester ID in an in-order ID FIFO, then routes the adder results back to the matching response channel.
- Sits between the vector-ops front end and the fadd datapath. The adder returns results in issue order.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- BIT_SIZE, 32, operand/result width.
- MAX_INFLIGHT, 8, max beats issued but not yet returned; this is also the ID FIFO depth (power of 2).
- ID_W, derived $clog2(NUM_REQ), localparam.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_a  in  [NUM_REQ][BIT_SIZE]  operand a per requester
- req_b  in  [NUM_REQ][BIT_SIZE]  operand b per requester
- req_sub  in  NUM_REQ  per-requester subtract select
- req_tlast  in  NUM_REQ  last beat of packet
- req_valid  in  NUM_REQ  beat valid
- req_ready  out  NUM_REQ  beat accepted
- add_a, add_b  out  BIT_SIZE  operands to adder
- add_sub  out  1  subtract to adder
- add_tlast  out  1  tlast to adder
- add_valid  out  1  issue valid
- add_ready  in  1  adder accepts
- add_res  in  BIT_SIZE  adder result
- add_res_tlast  in  1  result tlast
- add_res_valid  in  1  result valid
- add_res_ready  out  1  result accepted
- rsp_data  out  BIT_SIZE  shared response bus
- rsp_tlast  out  1  response tlast
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response ready
- grant_id  out  ID_W  current owner
- busy  out  1  state==LOCKED
- err_orphan  out  1  sticky: result arrived with ID FIFO empty

Behaviour:
- Reset (one clk with rst=1) clears the following:
  - state=IDLE, rr_ptr=0, grant_id=0;
  - ID FIFO pointers, inflight=0, err_orphan=0.
  - Consequently req_ready=0, add_valid=0, rsp_valid=0, busy=0.
  - Applies equally mid-packet; partially issued packets are abandoned. The adder must be reset in the same cycle.
- FSM IDLE:
  - If any req_valid is set, pick the first set index at or after rr_ptr (cyclic).
  - Register it into grant_id and go to LOCKED next cycle. This costs one bubble cycle per packet.
  - req_ready is all 0 in IDLE.
- FSM LOCKED:
  - can_issue = (inflight < MAX_INFLIGHT).
  - add_valid = req_valid[grant_id] && can_issue.
  - req_ready[grant_id] = add_ready && can_issue; all other req_ready=0.
  - add_a, add_b, add_sub, add_tlast are combinational muxes of the granted requester.
  - Issue handshake = add_valid && add_ready.
  - On an issue with tlast: go to IDLE and set rr_ptr = (grant_id+1) mod NUM_REQ.
- ID FIFO:
  - Push grant_id on every issue handshake.
  - head = FIFO output; ID FIFO has zero read latency.
  - rsp_valid[head] = add_res_valid && !fifo_empty; other bits 0.
  - rsp_data = add_res, rsp_tlast = add_res_tlast.
  - add_res_ready = rsp_ready[head] when FIFO non-empty.
  - Pop on add_res_valid && add_res_ready.
- inflight counter:
  - +1 on issue, -1 on pop, unchanged when both happen in the same cycle.
  - Never exceeds MAX_INFLIGHT; the FIFO never overflows because can_issue gates issue.
  - A push and pop together when inflight==MAX_INFLIGHT is impossible (no issue when full).
- Orphan result (add_res_valid with FIFO empty):
  - add_res_ready=1, result dropped, err_orphan set (held until rst).
- Backpressure independence: a stalled response (rsp_ready[head]=0) does not block issue until inflight reaches MAX_INFLIGHT.
- Single-beat packet (tlast on first beat): LOCKED lasts exactly one issue, then IDLE.

Decomposition:
- Package fadd_arb_pkg: state_t enum {IDLE, LOCKED}; function id_width(n) returning $clog2(n).
- One sub-module, fadd_rr_pick: combinational rotate-priority picker. Inputs are the valid vector and rr_ptr; outputs are the index and a found flag. It is reused by other arbiters.
- The ID FIFO is inline as a circular buffer with wr/rd pointers plus the inflight count.

Test Plan:
- Reset then idle: all req_valid=0 for 10 clk -> add_valid=0, busy=0, rsp_valid=0, grant_id=0.
- Two contenders: req0 and req1 each present 3-beat packets simultaneously, add_ready=1, adder latency 3 -> req0 beats issued cycles 2-4, bubble, req1 issued cycles 6-8; responses routed rsp_valid=0001 x3 then 0010 x3; rr_ptr=2 afterwards.
- Fairness: all 4 requesters continuously valid with 1-beat packets -> grant sequence 0,1,2,3,0,1.
- In-flight limit: MAX_INFLIGHT=8, rsp_ready=0 -> exactly 8 issues, then add_valid=0 while req_valid=1; raise rsp_ready for one beat -> exactly one more issue.
- Orphan: add_res_valid=1 with empty FIFO for one clk -> add_res_ready=1, rsp_valid=0, err_orphan=1 and stays 1 until rst.
- Reset mid-packet: assert rst during beat 2 of 4 -> next cycle busy=0, inflight=0, err_orphan=0; the new packet from req2 is granted normally.

Source files
------------

// File: rtl/fadd_arbiter_pkg.sv
// Shared types and helpers for the fadd round-robin arbiter and its picker.
package fadd_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fadd_arbiter_if.sv
// Requester, adder and response buses of the fadd arbiter.
// The master view belongs to the arbiter, the slave view to its surroundings.
interface fadd_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int BIT_SIZE = 32
);

  logic [NUM_REQ-1:0][BIT_SIZE-1:0] req_a;
  logic [NUM_REQ-1:0][BIT_SIZE-1:0] req_b;
  logic [NUM_REQ-1:0]               req_sub;
  logic [NUM_REQ-1:0]               req_tlast;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;

  logic [BIT_SIZE-1:0]              add_a;
  logic [BIT_SIZE-1:0]              add_b;
  logic                             add_sub;
  logic                             add_tlast;
  logic                             add_valid;
  logic                             add_ready;

  logic [BIT_SIZE-1:0]              add_res;
  logic                             add_res_tlast;
  logic                             add_res_valid;
  logic                             add_res_ready;

  logic [BIT_SIZE-1:0]              rsp_data;
  logic                             rsp_tlast;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ-1:0]               rsp_ready;

  modport master (
    input  req_a, req_b, req_sub, req_tlast, req_valid, add_ready,
    input  add_res, add_res_tlast, add_res_valid, rsp_ready,
    output req_ready, add_a, add_b, add_sub, add_tlast, add_valid,
    output add_res_ready, rsp_data, rsp_tlast, rsp_valid
  );

  modport slave (
    output req_a, req_b, req_sub, req_tlast, req_valid, add_ready,
    output add_res, add_res_tlast, add_res_valid, rsp_ready,
    input  req_ready, add_a, add_b, add_sub, add_tlast, add_valid,
    input  add_res_ready, rsp_data, rsp_tlast, rsp_valid
  );

endinterface

// File: rtl/fadd_arbiter_rr_pick.sv
// Rotate-priority picker: first set bit of valid_i at or after ptr_i, cyclically.
module fadd_rr_pick
  import fadd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               found_o
);

  logic [ID_W-1:0] cand_s;

  // Scan farthest offset first so the nearest valid requester wins last.
  always_comb begin
    idx_o   = ID_W'(0);
    found_o = 1'b0;
    cand_s  = ID_W'(0);
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand_s  = ID_W'((int'(ptr_i) + off) % NUM_REQ);
      idx_o   = valid_i[cand_s] ? cand_s : idx_o;
      found_o = found_o | valid_i[cand_s];
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Round-robin packet arbiter sharing one in-order streaming fadd among NUM_REQ requesters.
// Each issued beat is tagged with its owner in an ID FIFO so results route back to it.
module fadd_arbiter
  import fadd_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BIT_SIZE     = 32,
  parameter int MAX_INFLIGHT = 8,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst,
  fadd_arbiter_if.master  bus,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            err_orphan
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   fifo_q [MAX_INFLIGHT];

  logic [ID_W-1:0]     pick_idx_s;
  logic                pick_found_s;
  logic                can_issue_s;
  logic                fifo_empty_s;
  logic [ID_W-1:0]     head_s;
  logic                issue_s;
  logic                pop_s;
  logic [BIT_SIZE-1:0] op_a_s;
  logic [BIT_SIZE-1:0] op_b_s;

  fadd_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // Issue side: operand mux of the owner, gated by the in-flight budget.
  always_comb begin
    can_issue_s   = (inflight_q < CNT_W'(MAX_INFLIGHT));
    op_a_s        = bus.req_a[grant_q];
    op_b_s        = bus.req_b[grant_q];
    bus.add_a     = op_a_s;
    bus.add_b     = op_b_s;
    bus.add_sub   = bus.req_sub[grant_q];
    bus.add_tlast = bus.req_tlast[grant_q];
    bus.req_ready = {NUM_REQ{1'b0}};
    if (state_q == LOCKED) begin
      bus.add_valid          = bus.req_valid[grant_q] && can_issue_s;
      bus.req_ready[grant_q] = bus.add_ready && can_issue_s;
    end else begin
      bus.add_valid = 1'b0;
    end
    issue_s = bus.add_valid && bus.add_ready;
  end

  // Return side: the FIFO head names the response channel; orphans are sunk.
  always_comb begin
    fifo_empty_s      = (inflight_q == CNT_W'(0));
    head_s            = fifo_q[rd_ptr_q];
    bus.rsp_data      = bus.add_res;
    bus.rsp_tlast     = bus.add_res_tlast;
    bus.rsp_valid     = {NUM_REQ{1'b0}};
    bus.rsp_valid[head_s] = bus.add_res_valid && !fifo_empty_s;
    bus.add_res_ready = fifo_empty_s ? 1'b1 : bus.rsp_ready[head_s];
    pop_s             = bus.add_res_valid && bus.add_res_ready && !fifo_empty_s;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          state_d = LOCKED;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (issue_s && bus.add_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : grant_q + ID_W'(1);
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = issue_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    err_d    = err_q | (bus.add_res_valid && fifo_empty_s);
    case ({issue_s, pop_s})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= ID_W'(0);
      rr_ptr_q   <= ID_W'(0);
      wr_ptr_q   <= PTR_W'(0);
      rd_ptr_q   <= PTR_W'(0);
      inflight_q <= CNT_W'(0);
      err_q      <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) fifo_q[i] <= ID_W'(0);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (issue_s) fifo_q[wr_ptr_q] <= grant_q;
    end
  end

  assign grant_id   = grant_q;
  assign busy       = (state_q == LOCKED);
  assign err_orphan = err_q;

endmodule
